// File: rtl/tt_uart_pkg.sv
// Shared UART definitions for the tile's receive path and a future tt_uart_tx.
// Contents: the frame state encoding, the data width and the line idle level.
package tt_uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    // Even parity holds when the data bits and the parity bit XOR to zero.
    function automatic logic even_parity_bad(
        input logic [UART_DATA_W-1:0] d,
        input logic                   p
    );
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser for asynchronous tile inputs.
// Ports: clk, rst (sync, active-high), i_d async in, o_q synchronised out.
module tt_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tt_uart_rx.sv
// UART 8N1 receiver (LSB first) with a one-entry valid/ready output buffer.
// Ports: clk, rst (sync, active-high), rx_i serial line, data_o/valid_o/ready_i
// output buffer, busy_o not idle, frame_err_o and overrun_o one-cycle pulses.
// Build option TT_UART_RX_PARITY_EN adds an even parity bit and parity_err_o.
module tt_uart_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
`ifdef TT_UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o
);

    import tt_uart_pkg::*;

    localparam int IDX_W = $clog2(UART_DATA_W + 1);

    // First sample lands mid-start-bit; later samples are a full bit apart.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

    uart_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;
`ifdef TT_UART_RX_PARITY_EN
    logic                   r_perr;
    logic                   r_par_bad;
`endif

    logic w_rxs;
    logic w_sample;
    logic w_pop;
    logic w_bad;

    tt_sync2 #(
        .RST_VAL (UART_IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_i),
        .o_q (w_rxs)
    );

    assign w_sample = (r_cnt == '0);
    assign w_pop    = r_valid & ready_i;

`ifdef TT_UART_RX_PARITY_EN
    assign w_bad = r_par_bad;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef TT_UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            // A load in the STOP branch below overrides this clear.
            if (w_pop) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rxs != UART_IDLE_LVL) begin
                        r_state <= START;
                        r_cnt   <= CNT_HALF;
                    end
                end

                START: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rxs != UART_IDLE_LVL) begin
                        r_state <= DATA;
                        r_cnt   <= CNT_FULL;
                        r_idx   <= '0;
                    end else begin
                        // Line was back high mid-start-bit: a glitch.
                        r_state <= IDLE;
                    end
                end

                DATA: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rxs, r_shift[UART_DATA_W-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= CNT_FULL;
                        if (r_idx == IDX_LAST) begin
`ifdef TT_UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end

`ifdef TT_UART_RX_PARITY_EN
                PARITY: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_par_bad <= even_parity_bad(r_shift, w_rxs);
                        r_state   <= STOP;
                        r_cnt     <= CNT_FULL;
                    end
                end
`endif

                STOP: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rxs == UART_IDLE_LVL) begin
                        r_state <= IDLE;
                        if (w_bad) begin
`ifdef TT_UART_RX_PARITY_EN
                            r_perr <= 1'b1;
`endif
                        end else if (!r_valid || w_pop) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end else begin
                        // Stop bit low: drop the byte and wait out the break.
                        r_ferr  <= 1'b1;
                        r_state <= BREAK;
`ifdef TT_UART_RX_PARITY_EN
                        r_perr  <= r_par_bad;
`endif
                    end
                end

                BREAK: begin
                    if (w_rxs == UART_IDLE_LVL) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = (r_state != IDLE);
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
`ifdef TT_UART_RX_PARITY_EN
    assign parity_err_o = r_perr;
`endif

endmodule

// File: tb/tb_tt_uart_rx.sv
// Directed bench for tt_uart_rx at CLKS_PER_BIT=8.
// Table of single-frame vectors plus hand-written multi-cycle sequences.
module tb_tt_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;
`ifdef TT_UART_RX_PARITY_EN
    logic       parity_err_o;
    logic       par_flip = 1'b0;
    int         n_perr = 0;
`endif

    int checks = 0;
    int errors = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    logic [7:0] popq[$];

    tt_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
`ifdef TT_UART_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (valid_o && ready_i) popq.push_back(data_o);
`ifdef TT_UART_RX_PARITY_EN
        if (parity_err_o) n_perr++;
`endif
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_ovr;
        int         exp_pops;
    } vec_t;

    vec_t vecs[7];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rx_i = 1'b1;
        ready_i = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Leaves rx_i at the stop-bit level; callers return the line high.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            tick(CPB);
        end
`ifdef TT_UART_RX_PARITY_EN
        rx_i = (^d) ^ par_flip;
        tick(CPB);
`endif
        rx_i = stop;
        tick(CPB);
    endtask

    initial begin
        int bf, bo, ps, bad;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 0, 0, 0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 0, 0, 1};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 0, 1};

        do_reset();
        chk("reset_outs", {data_o, valid_o, busy_o, frame_err_o, overrun_o},
            32'h0);

        foreach (vecs[k]) begin
            do_reset();
            ready_i = vecs[k].rdy;
            bf = n_ferr;
            bo = n_ovr;
            ps = popq.size();
            send_frame(vecs[k].data, vecs[k].stop);
            rx_i = 1'b1;
            tick(20);
            chk($sformatf("v%0d_valid", k), valid_o, vecs[k].exp_valid);
            chk($sformatf("v%0d_data", k), data_o, vecs[k].exp_data);
            chk($sformatf("v%0d_ferr", k), n_ferr - bf, vecs[k].exp_ferr);
            chk($sformatf("v%0d_ovr", k), n_ovr - bo, vecs[k].exp_ovr);
            chk($sformatf("v%0d_pops", k), popq.size() - ps,
                vecs[k].exp_pops);
            if (popq.size() > ps)
                chk($sformatf("v%0d_popdata", k), popq[ps], vecs[k].exp_data);
            chk($sformatf("v%0d_busy", k), busy_o, 0);
            ready_i = 1'b0;
        end

        // Byte held while not consumed, then a single-cycle pop.
        do_reset();
        ps = popq.size();
        send_frame(8'hA5, 1'b1);
        rx_i = 1'b1;
        tick(4);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (valid_o !== 1'b1 || data_o !== 8'hA5) bad++;
            tick(1);
        end
        chk("hold50", bad, 0);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        chk("pop_clears", valid_o, 0);
        chk("pop_count", popq.size() - ps, 1);

        // Back-to-back with a full buffer: second byte overruns.
        do_reset();
        bo = n_ovr;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        rx_i = 1'b1;
        tick(20);
        chk("b2b_valid", valid_o, 1);
        chk("b2b_data", data_o, 8'h3C);
        chk("b2b_ovr", n_ovr - bo, 1);

        // Back-to-back with ready held high: both bytes delivered.
        do_reset();
        ready_i = 1'b1;
        bo = n_ovr;
        ps = popq.size();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        rx_i = 1'b1;
        tick(20);
        chk("b2br_pops", popq.size() - ps, 2);
        if (popq.size() >= ps + 2) begin
            chk("b2br_d0", popq[ps], 8'h3C);
            chk("b2br_d1", popq[ps+1], 8'hC3);
        end
        chk("b2br_ovr", n_ovr - bo, 0);
        chk("b2br_valid", valid_o, 0);
        ready_i = 1'b0;

        // Frame error with line held low, then recovery.
        do_reset();
        bf = n_ferr;
        send_frame(8'h55, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o !== 1'b1) bad++;
            tick(1);
        end
        chk("brk_busy", bad, 0);
        chk("brk_ferr", n_ferr - bf, 1);
        chk("brk_valid", valid_o, 0);
        rx_i = 1'b1;
        tick(6);
        chk("brk_idle", busy_o, 0);
        send_frame(8'h12, 1'b1);
        rx_i = 1'b1;
        tick(4);
        chk("after_brk_valid", valid_o, 1);
        chk("after_brk_data", data_o, 8'h12);
        chk("after_brk_ferr", n_ferr - bf, 1);

        // Short low glitch is rejected.
        do_reset();
        bf = n_ferr;
        bo = n_ovr;
        rx_i = 1'b0;
        tick(3);
        chk("glitch_busy", busy_o, 1);
        rx_i = 1'b1;
        tick(6);
        chk("glitch_idle", busy_o, 0);
        chk("glitch_valid", valid_o, 0);
        chk("glitch_flags", (n_ferr - bf) + (n_ovr - bo), 0);

        // Reset mid-frame drops the buffered byte and the frame.
        do_reset();
        send_frame(8'h3C, 1'b1);
        rx_i = 1'b1;
        tick(4);
        chk("pre_rst_valid", valid_o, 1);
        rx_i = 1'b0;
        tick(CPB);
        rx_i = 1'b1;
        tick(4 * CPB + 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_outs", {data_o, valid_o, busy_o, frame_err_o, overrun_o},
            32'h0);
        tick(60);
        send_frame(8'hFF, 1'b1);
        rx_i = 1'b1;
        tick(4);
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_data", data_o, 8'hFF);

`ifdef TT_UART_RX_PARITY_EN
        do_reset();
        bf = n_perr;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        rx_i = 1'b1;
        tick(10);
        chk("par_bad_perr", n_perr - bf, 1);
        chk("par_bad_valid", valid_o, 0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        rx_i = 1'b1;
        tick(10);
        chk("par_ok_valid", valid_o, 1);
        chk("par_ok_data", data_o, 8'h07);
        chk("par_ok_perr", n_perr - bf, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
